dst_write_memory: RTL and testbench

DST_WRITE_MEMORY -- requirements
Module: dst_write_memory

---
 rtl/dst_mem_pkg.sv | 13 +
 rtl/wbuf_fifo.sv | 55 +++++
 rtl/dst_write_memory.sv | 122 ++++++++++++
 tb/tb_dst_write_memory.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dst_mem_pkg.sv
// Shared types and default sizes for the posted-write memory block.
package dst_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_WBUF_DEPTH = 4;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write FIFO holding {addr, data}; every slot plus the read pointer is
// exposed so the parent can search pending writes for read forwarding.
module wbuf_fifo
  import dst_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_WBUF_DEPTH,
  parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_addr,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [ADDR_W-1:0]              head_addr,
  output logic [DATA_W-1:0]              head_data,
  output logic [CNT_W-1:0]               count,
  output logic [PTR_W-1:0]               rd_ptr,
  output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]   ent_data
);

  logic [PTR_W-1:0]              wr_ptr;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_q;
  logic [DEPTH-1:0][DATA_W-1:0]  data_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign ent_addr  = addr_q;
  assign ent_data  = data_q;

endmodule

// File: rtl/dst_write_memory.sv
// Single-port memory fronted by a posted-write buffer with flush control.
// Define DST_MEM_FORWARD_EN to let reads see the newest pending buffered write.
module dst_write_memory
  import dst_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              busy
);

  localparam int MEM_N = 2 ** ADDR_W;
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  state_t                            state_q, state_d;
  logic [DATA_W-1:0]                 mem_q [MEM_N];
  logic [CNT_W-1:0]                  count;
  logic [PTR_W-1:0]                  fifo_rd_ptr;
  logic [ADDR_W-1:0]                 head_addr;
  logic [DATA_W-1:0]                 head_data;
  logic [WBUF_DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [WBUF_DEPTH-1:0][DATA_W-1:0] ent_data;
  logic                              push, drain, rd_fire;
  logic [DATA_W-1:0]                 rd_value;
  logic                              vld_p1;
  logic [DATA_W-1:0]                 rd_data_p1;

  assign busy     = (count != '0);
  assign wr_ready = (count < FULL_CNT) && (state_q != FLUSH);
  assign push     = wr_valid && wr_ready;
  // One array access per cycle: IDLE favours reads, FLUSH favours draining.
  assign drain    = busy && ((state_q == FLUSH) || !rd_en);
  assign rd_fire  = rd_en && !drain;

  wbuf_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (drain),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .rd_ptr    (fifo_rd_ptr),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      IDLE:  if (flush_req) state_d = FLUSH;
      FLUSH: if (!busy) begin
        state_d    = IDLE;
        flush_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DST_MEM_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to newest so the last match is the most recent write.
  always_comb begin
    rd_value = mem_q[rd_addr];
    fwd_idx  = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_idx = fifo_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_addr[fwd_idx] == rd_addr))
        rd_value = ent_data[fwd_idx];
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fifo_rd_ptr, ent_addr, ent_data};
  assign rd_value   = mem_q[rd_addr];
`endif

  // Stage p1: registered read result and array drain write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_fire;
      if (rd_fire) rd_data_p1 <= rd_value;
      if (drain)   mem_q[head_addr] <= head_data;
    end
  end

  assign rd_valid = vld_p1;
  assign rd_data  = rd_data_p1;

endmodule

// File: tb/tb_dst_write_memory.sv
// Directed plus random bench for dst_write_memory with a queue-based reference model.
module tb_dst_write_memory;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       flush_req = 1'b0;
  logic       flush_done;
  logic       busy;

  dst_write_memory dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } ent_t;

  logic [7:0] m_mem [8];
  ent_t       q [$];
  bit         m_flush;
  logic       m_rv;
  logic [7:0] m_rd;
  bit         armed = 1'b0;
  int         compared = 0;
  int         mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [2:0] wa, input logic [7:0] wd,
                      input logic re, input logic [2:0] ra, input logic fr, input logic rs);
    int         n;
    bit         acc, drn;
    logic [7:0] val;
    ent_t       e;
    wr_valid = v; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; flush_req = fr; reset = rs;
    @(negedge clk);
    if (armed) begin
      check("wr_ready",   wr_ready,   32'(q.size() < 4 && !m_flush));
      check("busy",       busy,       32'(q.size() != 0));
      check("flush_done", flush_done, 32'(m_flush && q.size() == 0));
      check("rd_valid",   rd_valid,   32'(m_rv));
      check("rd_data",    rd_data,    32'(m_rd));
    end
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      q.delete();
      m_flush = 1'b0;
      m_rv    = 1'b0;
      m_rd    = 8'h00;
      armed   = 1'b1;
    end else begin
      n   = q.size();
      acc = v && (n < 4) && !m_flush;
      drn = (n != 0) && (m_flush || !re);
      if (re && !drn) begin
        val = m_mem[ra];
`ifdef DST_MEM_FORWARD_EN
        for (int i = 0; i < n; i++) if (q[i].a == ra) val = q[i].d;
`endif
        m_rv = 1'b1;
        m_rd = val;
      end else begin
        m_rv = 1'b0;
      end
      if (m_flush) begin
        if (n == 0) m_flush = 1'b0;
      end else if (fr) begin
        m_flush = 1'b1;
      end
      if (drn) begin
        e = q.pop_front();
        m_mem[e.a] = e.d;
      end
      if (acc) q.push_back('{a: wa, d: wd});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and post-reset state
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Simple write, wait, read back
    step(1, 3'd2, 8'hA5, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 3'd2, 0, 0);
    check("basic_rd_valid", rd_valid, 1);
    check("basic_rd_data", rd_data, 32'hA5);
    idle(1);

    // Reads hold off draining until the buffer fills
    for (int i = 0; i < 5; i++) step(1, 3'(i), 8'(8'h10 + i), 1, 3'd7, 0, 0);
    check("full_wr_ready", wr_ready, 0);
    check("full_busy", busy, 1);
    idle(6);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 3'(i), 0, 0);
    idle(1);

    // Two writes to one address, read while they are still pending
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 3'd5, 8'h3C, 1, 3'd0, 0, 0);
    step(1, 3'd5, 8'h7E, 1, 3'd0, 0, 0);
    step(0, 0, 0, 1, 3'd5, 0, 0);
`ifdef DST_MEM_FORWARD_EN
    check("fwd_rd_data", rd_data, 32'h7E);
`else
    check("nofwd_rd_data", rd_data, 32'h00);
`endif
    idle(4);
    step(0, 0, 0, 1, 3'd5, 0, 0);
    check("drained_rd_data", rd_data, 32'h7E);

    // Flush with three pending writes
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 3'(i + 1), 8'(8'hC0 + i), 1, 3'd0, 0, 0);
    step(0, 0, 0, 1, 3'd0, 1, 0);
    check("flush_wr_ready", wr_ready, 0);
    for (int i = 0; i < 3; i++) step(1, 3'd6, 8'hEE, 1, 3'd1, 0, 0);
    check("flush_done_pulse", flush_done, 1);
    step(0, 0, 0, 1, 3'd1, 0, 0);
    check("flush_done_clear", flush_done, 0);
    for (int i = 1; i < 4; i++) step(0, 0, 0, 1, 3'(i), 0, 0);
    check("flush_arr_3", rd_data, 32'hC2);
    idle(1);

    // Flush while already empty completes one cycle later
    step(0, 0, 0, 0, 0, 1, 0);
    check("empty_flush_done", flush_done, 1);
    idle(1);

    // Reset discards a full buffer
    for (int i = 0; i < 4; i++) step(1, 3'(i), 8'(8'h50 + i), 1, 3'd7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_busy", busy, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 3'(i), 0, 0);
    idle(1);

    // Same-cycle push and pop across a pointer wrap
    step(1, 3'd0, 8'h90, 1, 3'd0, 0, 0);
    for (int i = 1; i < 9; i++) step(1, 3'(i), 8'(8'h90 + i), 0, 0, 0, 0);
    check("wrap_busy", busy, 1);
    idle(3);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 3'(i), 0, 0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) == 0), 3'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
